counter_seq_ctrl: RTL and testbench

Sequencing controller for the team's 4-bit up/down counter pair. A host configures a terminal value and run mode, arms the block, and starts it. The controller steps the up counter through epochs and decrements the down (epoch) counter at each terminal match. It also handles pause, abort and completion reporting. It sits between the host control/status logic and the counter datapath, which lives inside this block.

---
 rtl/counter_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Sequencing controller wrapped around a WIDTH-bit up counter (position inside
// an epoch) and a WIDTH-bit down counter (epochs remaining). The host loads a
// terminal value and a run mode, arms the block and then starts it. The block
// walks the up counter from 0 to the terminal value once per epoch. It
// decrements the down counter at each terminal match. It also handles pause,
// abort and a one-cycle completion pulse.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   cfg_valid   configuration offer (only taken in IDLE)
//   cfg_ready   configuration accept, high only in IDLE
//   cfg_limit   terminal value for up_count
//   cfg_reload  0 = single epoch, 1 = repeat epochs until down_count hits 0
//   start       begin run (only honoured in ARMED)
//   pause       level, freezes the counters while high
//   abort       cancel the run and return to IDLE
//   up_count    registered up counter
//   down_count  registered epoch counter
//   busy        high in RUN and HOLD
//   paused      high in HOLD
//   done        one-cycle completion pulse
//   run_cycles  (only with COUNTER_SEQ_CTRL_CYCLES_EN) saturating count of
//               RUN cycles since the last start
//
// Optional feature macro: COUNTER_SEQ_CTRL_CYCLES_EN

module counter_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic               cfg_reload,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  output logic [WIDTH-1:0]   up_count,
  output logic [WIDTH-1:0]   down_count,
  output logic               busy,
  output logic               paused,
  output logic               done
`ifdef COUNTER_SEQ_CTRL_CYCLES_EN
  ,
  output logic [2*WIDTH-1:0] run_cycles
`endif
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] lim_r;
  logic [WIDTH-1:0] lim_s;
  logic             reload_r;
  logic             reload_s;
  logic [WIDTH-1:0] up_s;
  logic [WIDTH-1:0] down_s;
  logic             clr_cycles_s;

  // Next-state and counter update; RUN conditions are evaluated in priority order
  always_comb begin
    state_s      = state_r;
    lim_s        = lim_r;
    reload_s     = reload_r;
    up_s         = up_count;
    down_s       = down_count;
    clr_cycles_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg_valid) begin
          lim_s    = cfg_limit;
          reload_s = cfg_reload;
          state_s  = ARMED;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        if (abort) begin
          state_s = IDLE;
        end else if (start) begin
          state_s      = RUN;
          up_s         = CNT_ZERO;
          down_s       = CNT_ONES;
          clr_cycles_s = 1'b1;
        end else begin
          state_s = ARMED;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
          up_s    = CNT_ZERO;
          down_s  = CNT_ONES;
        end else if (pause) begin
          state_s = HOLD;
        end else if (up_count == lim_r) begin
          up_s   = CNT_ZERO;
          down_s = down_count - CNT_ONE;
          // Reload runs stop once the epoch counter reaches 0, so it never wraps
          if (!reload_r || (down_s == CNT_ZERO)) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          up_s = up_count + CNT_ONE;
        end
      end
      HOLD: begin
        if (abort) begin
          state_s = IDLE;
          up_s    = CNT_ZERO;
          down_s  = CNT_ONES;
        end else if (!pause) begin
          state_s = RUN;
        end else begin
          state_s = HOLD;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        up_s    = CNT_ZERO;
        down_s  = CNT_ONES;
      end
    endcase
  end

  // State, configuration, counter and status registers. The status flags are
  // decoded from the next state, so each one always matches the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      lim_r      <= CNT_ONES;
      reload_r   <= 1'b0;
      up_count   <= CNT_ZERO;
      down_count <= CNT_ONES;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
      paused     <= 1'b0;
      done       <= 1'b0;
`ifdef COUNTER_SEQ_CTRL_CYCLES_EN
      run_cycles <= {(2*WIDTH){1'b0}};
`endif
    end else begin
      state_r    <= state_s;
      lim_r      <= lim_s;
      reload_r   <= reload_s;
      up_count   <= up_s;
      down_count <= down_s;
      cfg_ready  <= (state_s == IDLE);
      busy       <= (state_s == RUN) || (state_s == HOLD);
      paused     <= (state_s == HOLD);
      done       <= (state_s == DONE);
`ifdef COUNTER_SEQ_CTRL_CYCLES_EN
      // Every RUN cycle is counted, including one that leaves on abort or pause
      if (clr_cycles_s) begin
        run_cycles <= {(2*WIDTH){1'b0}};
      end else if ((state_r == RUN) && (run_cycles != {(2*WIDTH){1'b1}})) begin
        run_cycles <= run_cycles + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
        run_cycles <= run_cycles;
      end
`endif
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl. Inputs change and outputs
// are sampled on the falling edge. The design updates on the rising edge.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_limit = 4'd0;
  logic       cfg_reload = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] up_count;
  logic [3:0] down_count;
  logic       busy;
  logic       paused;
  logic       done;
`ifdef COUNTER_SEQ_CTRL_CYCLES_EN
  logic [7:0] run_cycles;
`endif

  int vectors = 0;
  int errors  = 0;

  counter_seq_ctrl #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_limit  (cfg_limit),
    .cfg_reload (cfg_reload),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .up_count   (up_count),
    .down_count (down_count),
    .busy       (busy),
    .paused     (paused),
    .done       (done)
`ifdef COUNTER_SEQ_CTRL_CYCLES_EN
    ,
    .run_cycles (run_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic configure(input logic [3:0] lim, input logic rel);
    cfg_limit  = lim;
    cfg_reload = rel;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic start_run;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (up_count !== 4'd0) begin errors++; $display("FAIL reset_up: got %0d expected 0", up_count); end
    vectors++; if (down_count !== 4'd15) begin errors++; $display("FAIL reset_down: got %0d expected 15", down_count); end
    vectors++; if ({cfg_ready, busy, paused, done} !== 4'b1000) begin errors++; $display("FAIL reset_flags: got %b expected 1000", {cfg_ready, busy, paused, done}); end
    rst = 1'b0;
    // start offered together with the configuration in IDLE must not launch a run
    cfg_limit = 4'd5; cfg_reload = 1'b0; cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    vectors++; if ({cfg_ready, busy} !== 2'b00) begin errors++; $display("FAIL idle_start_ignored: got %b expected 00", {cfg_ready, busy}); end
    tick();
    vectors++; if ({cfg_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL armed_holds: got %b expected 000", {cfg_ready, busy, done}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL armed_abort: got %b expected 1", cfg_ready); end
  endtask

  task automatic test_one_shot;
    configure(4'd12, 1'b0);
    start_run();
    for (int i = 0; i <= 12; i++) begin
      vectors++; if (up_count !== 4'(i) || busy !== 1'b1 || down_count !== 4'd15) begin
        errors++; $display("FAIL one_shot_step%0d: got up=%0d down=%0d busy=%b expected up=%0d down=15 busy=1", i, up_count, down_count, busy, i);
      end
      tick();
    end
    vectors++; if ({done, busy, up_count, down_count} !== {1'b1, 1'b0, 4'd0, 4'd14}) begin
      errors++; $display("FAIL one_shot_terminal: got done=%b busy=%b up=%0d down=%0d expected 1 0 0 14", done, busy, up_count, down_count);
    end
    tick();
    vectors++; if ({done, busy, cfg_ready, up_count, down_count} !== {1'b0, 1'b0, 1'b1, 4'd0, 4'd14}) begin
      errors++; $display("FAIL one_shot_idle: got done=%b busy=%b rdy=%b up=%0d down=%0d expected 0 0 1 0 14", done, busy, cfg_ready, up_count, down_count);
    end
  endtask

  task automatic test_auto_reload;
    int cyc;
    int dones;
    cyc = 0;
    dones = 0;
    configure(4'd2, 1'b1);
    start_run();
    while (busy === 1'b1 && cyc < 100) begin
      vectors++; if (up_count !== 4'(cyc % 3) || down_count !== 4'(15 - cyc / 3)) begin
        errors++; $display("FAIL reload_cyc%0d: got up=%0d down=%0d expected up=%0d down=%0d", cyc, up_count, down_count, cyc % 3, 15 - cyc / 3);
      end
      tick();
      cyc++;
      if (done === 1'b1) dones++;
    end
    vectors++; if (cyc !== 45) begin errors++; $display("FAIL reload_length: got %0d expected 45", cyc); end
    vectors++; if ({done, up_count, down_count} !== {1'b1, 4'd0, 4'd0}) begin
      errors++; $display("FAIL reload_final: got done=%b up=%0d down=%0d expected 1 0 0", done, up_count, down_count);
    end
`ifdef COUNTER_SEQ_CTRL_CYCLES_EN
    vectors++; if (run_cycles !== 8'd45) begin errors++; $display("FAIL reload_run_cycles: got %0d expected 45", run_cycles); end
`endif
    tick();
    if (done === 1'b1) dones++;
    tick();
    vectors++; if (dones !== 1) begin errors++; $display("FAIL reload_done_pulses: got %0d expected 1", dones); end
    vectors++; if ({cfg_ready, down_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL reload_idle: got rdy=%b down=%0d expected 1 0", cfg_ready, down_count); end
  endtask

  task automatic test_pause;
    configure(4'd9, 1'b0);
    start_run();
    repeat (5) tick();
    vectors++; if (up_count !== 4'd5) begin errors++; $display("FAIL pause_pre: got %0d expected 5", up_count); end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if ({paused, busy, up_count} !== {1'b1, 1'b1, 4'd5}) begin
        errors++; $display("FAIL pause_hold%0d: got paused=%b busy=%b up=%0d expected 1 1 5", i, paused, busy, up_count);
      end
    end
    pause = 1'b0;
    tick();
    vectors++; if ({paused, up_count} !== {1'b0, 4'd5}) begin errors++; $display("FAIL pause_release: got paused=%b up=%0d expected 0 5", paused, up_count); end
    tick();
    vectors++; if (up_count !== 4'd6) begin errors++; $display("FAIL pause_resume: got %0d expected 6", up_count); end
    repeat (3) tick();
    pause = 1'b1;
    tick();
    vectors++; if ({paused, up_count, down_count} !== {1'b1, 4'd9, 4'd15}) begin
      errors++; $display("FAIL pause_terminal: got paused=%b up=%0d down=%0d expected 1 9 15", paused, up_count, down_count);
    end
    pause = 1'b0;
    tick();
    tick();
    vectors++; if ({done, up_count, down_count} !== {1'b1, 4'd0, 4'd14}) begin
      errors++; $display("FAIL pause_done: got done=%b up=%0d down=%0d expected 1 0 14", done, up_count, down_count);
    end
`ifdef COUNTER_SEQ_CTRL_CYCLES_EN
    vectors++; if (run_cycles !== 8'd12) begin errors++; $display("FAIL pause_run_cycles: got %0d expected 12", run_cycles); end
`endif
    tick();
  endtask

  task automatic test_abort;
    configure(4'd9, 1'b0);
    start_run();
    repeat (7) tick();
    vectors++; if (up_count !== 4'd7) begin errors++; $display("FAIL abort_pre: got %0d expected 7", up_count); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if ({cfg_ready, busy, done, up_count, down_count} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd15}) begin
      errors++; $display("FAIL abort_run: got rdy=%b busy=%b done=%b up=%0d down=%0d expected 1 0 0 0 15", cfg_ready, busy, done, up_count, down_count);
    end
    tick();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", done); end
    // abort and pause together while running
    configure(4'd9, 1'b0);
    start_run();
    tick();
    abort = 1'b1; pause = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    vectors++; if ({cfg_ready, busy, paused, up_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL abort_pause: got rdy=%b busy=%b paused=%b up=%0d expected 1 0 0 0", cfg_ready, busy, paused, up_count);
    end
    // abort from HOLD
    configure(4'd9, 1'b0);
    start_run();
    repeat (2) tick();
    pause = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    vectors++; if ({cfg_ready, paused, up_count, down_count} !== {1'b1, 1'b0, 4'd0, 4'd15}) begin
      errors++; $display("FAIL abort_hold: got rdy=%b paused=%b up=%0d down=%0d expected 1 0 0 15", cfg_ready, paused, up_count, down_count);
    end
    // abort and start together in ARMED
    configure(4'd3, 1'b0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    vectors++; if ({cfg_ready, busy} !== 2'b10) begin errors++; $display("FAIL abort_start_armed: got %b expected 10", {cfg_ready, busy}); end
  endtask

  task automatic test_limit_zero;
    int cyc;
    cyc = 0;
    configure(4'd0, 1'b1);
    start_run();
    while (busy === 1'b1 && cyc < 100) begin
      vectors++; if (up_count !== 4'd0 || down_count !== 4'(15 - cyc)) begin
        errors++; $display("FAIL lim0_cyc%0d: got up=%0d down=%0d expected up=0 down=%0d", cyc, up_count, down_count, 15 - cyc);
      end
      tick();
      cyc++;
    end
    vectors++; if (cyc !== 15) begin errors++; $display("FAIL lim0_length: got %0d expected 15", cyc); end
    vectors++; if ({done, down_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL lim0_done: got done=%b down=%0d expected 1 0", done, down_count); end
    tick();
  endtask

  task automatic test_reset_mid_run;
    configure(4'd5, 1'b1);
    start_run();
    repeat (3) tick();
    rst = 1'b1; pause = 1'b1;
    tick();
    rst = 1'b0; pause = 1'b0;
    vectors++; if ({cfg_ready, busy, paused, done, up_count, down_count} !== {4'b1000, 4'd0, 4'd15}) begin
      errors++; $display("FAIL reset_mid_run: got flags=%b up=%0d down=%0d expected 1000 0 15", {cfg_ready, busy, paused, done}, up_count, down_count);
    end
`ifdef COUNTER_SEQ_CTRL_CYCLES_EN
    vectors++; if (run_cycles !== 8'd0) begin errors++; $display("FAIL reset_run_cycles: got %0d expected 0", run_cycles); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_abort();
    test_limit_zero();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
